// File: rtl/rr_tag_arbiter.sv
// Round-robin arbiter that offers one requester index as a tag per grant.
// Optional 32-bit grant counter port enabled by RR_TAG_ARBITER_GRANT_CNT_EN.
module rr_tag_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_SZ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_rdy,
  output logic [N_REQ-1:0]  req_ack,
  output logic [TAG_SZ-1:0] tag,
  output logic              rdy,
  input  logic              ack
`ifdef RR_TAG_ARBITER_GRANT_CNT_EN
  ,
  output logic [31:0]       grant_cnt
`endif
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n
    $error("rr_tag_arbiter: N_REQ out of range 2..16");
  end
  if (TAG_SZ < PW) begin : g_bad_tag
    $error("rr_tag_arbiter: TAG_SZ smaller than clog2(N_REQ)");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [PW-1:0]     cur, cur_n;
  logic [PW:0]       hit;
  logic [PW-1:0]     nxt;

  // Returns {found, index}; lowest offset from start wins, cnt limits the window.
  function automatic logic [PW:0] scan(
    input logic [N_REQ-1:0] r,
    input int               start,
    input int               cnt
  );
    logic [PW:0] res;
    int          j;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (start + k) % N_REQ;
      if (k < cnt && r[j]) res = {1'b1, PW'(j)};
    end
    return res;
  endfunction

  always_comb begin
    nxt = (int'(cur) == N_REQ - 1) ? '0 : cur + 1'b1;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cur_n   = cur;
    hit     = '0;
    unique case (state)
      IDLE: begin
        hit = scan(req_rdy, int'(ptr), N_REQ);
        if (hit[PW]) begin
          cur_n   = hit[PW-1:0];
          state_n = OFFER;
        end
      end
      OFFER: begin
        if (ack) begin
          // Window of N_REQ-1 starting after cur skips cur itself.
          hit   = scan(req_rdy, int'(nxt), N_REQ - 1);
          ptr_n = nxt;
          if (hit[PW]) cur_n = hit[PW-1:0];
          else state_n = IDLE;
        end else if (!req_rdy[cur]) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cur   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cur   <= cur_n;
    end
  end

  assign rdy = (state == OFFER);
  assign tag = TAG_SZ'(cur);

  always_comb begin
    req_ack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ack[i] = ack && rdy && !rst && (int'(cur) == i);
    end
  end

`ifdef RR_TAG_ARBITER_GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) grant_cnt <= '0;
    else if (rdy && ack) grant_cnt <= grant_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rr_tag_arbiter.sv
// Directed bench for rr_tag_arbiter (N_REQ=4, TAG_SZ=2).
module tb_rr_tag_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_rdy;
  logic [3:0] req_ack;
  logic [1:0] tag;
  logic       rdy;
  logic       ack;
`ifdef RR_TAG_ARBITER_GRANT_CNT_EN
  logic [31:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  rr_tag_arbiter #(.N_REQ(4), .TAG_SZ(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_rdy (req_rdy),
    .req_ack (req_ack),
    .tag     (tag),
    .rdy     (rdy),
    .ack     (ack)
`ifdef RR_TAG_ARBITER_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_rdy = 4'b0000; ack = 1'b1;
    tick(); tick();
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_tag", 32'(tag), 32'd0);
    chk("rst_req_ack", 32'(req_ack), 32'd0);

    // sustained load, all ready
    rst = 1'b0; req_rdy = 4'b1111; ack = 1'b1;
    #1;
    chk("idle_ack_ignored", 32'(req_ack), 32'd0);
    tick();
    chk("full_rdy0", 32'(rdy), 32'd1);
    chk("full_tag0", 32'(tag), 32'd0);
    chk("full_ack0", 32'(req_ack), 32'b0001);
    tick();
    chk("full_tag1", 32'(tag), 32'd1);
    chk("full_ack1", 32'(req_ack), 32'b0010);
    tick();
    chk("full_tag2", 32'(tag), 32'd2);
    chk("full_ack2", 32'(req_ack), 32'b0100);
    tick();
    chk("full_tag3", 32'(tag), 32'd3);
    chk("full_ack3", 32'(req_ack), 32'b1000);
    tick();
    chk("full_tag0_wrap", 32'(tag), 32'd0);
    chk("full_rdy_wrap", 32'(rdy), 32'd1);
    ack = 1'b0; req_rdy = 4'b0000;
    tick();
    chk("withdraw_idle", 32'(rdy), 32'd0);

    // single requester held, ack after 3 cycles
    req_rdy = 4'b0100;
    tick();
    chk("single_rdy", 32'(rdy), 32'd1);
    chk("single_tag_a", 32'(tag), 32'd2);
    tick();
    chk("single_tag_b", 32'(tag), 32'd2);
    tick();
    chk("single_tag_c", 32'(tag), 32'd2);
    chk("single_noack", 32'(req_ack), 32'd0);
    ack = 1'b1;
    #1;
    chk("single_tag_d", 32'(tag), 32'd2);
    chk("single_req_ack", 32'(req_ack), 32'b0100);
    tick();
    ack = 1'b0; req_rdy = 4'b0011;
    chk("single_to_idle", 32'(rdy), 32'd0);

    // ptr=3: wrap to 0, then 1
    tick();
    chk("wrap_tag0", 32'(tag), 32'd0);
    ack = 1'b1;
    #1;
    chk("wrap_ack0", 32'(req_ack), 32'b0001);
    tick();
    chk("wrap_tag1", 32'(tag), 32'd1);
    chk("wrap_rdy1", 32'(rdy), 32'd1);

    // withdrawal without ack keeps ptr=1
    ack = 1'b0; req_rdy = 4'b0001;
    tick();
    chk("wd_rdy", 32'(rdy), 32'd0);
    req_rdy = 4'b0011;
    tick();
    chk("wd_ptr_kept", 32'(tag), 32'd1);

    // withdrawal with ack: ack wins
    req_rdy = 4'b0001; ack = 1'b1;
    #1;
    chk("wd_ack_wins", 32'(req_ack), 32'b0010);
    tick();
    chk("wd_ack_next_tag", 32'(tag), 32'd0);
    chk("wd_ack_next_rdy", 32'(rdy), 32'd1);

    // move to tag 2, then reset mid-offer
    req_rdy = 4'b0100;
    tick();
    chk("pre_rst_tag", 32'(tag), 32'd2);
    rst = 1'b1; req_rdy = 4'b1111; ack = 1'b1;
    #1;
    chk("rst_suppress_ack", 32'(req_ack), 32'd0);
    tick();
    chk("rst_mid_rdy", 32'(rdy), 32'd0);
    chk("rst_mid_tag", 32'(tag), 32'd0);
    rst = 1'b0; ack = 1'b0; req_rdy = 4'b0011;
    tick();
    chk("post_rst_tag", 32'(tag), 32'd0);
    chk("post_rst_rdy", 32'(rdy), 32'd1);

`ifdef RR_TAG_ARBITER_GRANT_CNT_EN
    rst = 1'b1;
    tick();
    chk("cnt_rst", grant_cnt, 32'd0);
    rst = 1'b0; req_rdy = 4'b1111; ack = 1'b1;
    tick();
    repeat (10) tick();
    chk("cnt_10", grant_cnt, 32'd10);
    rst = 1'b1;
    tick();
    chk("cnt_clear", grant_cnt, 32'd0);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_tag_arbiter.md
RR_TAG_ARBITER -- requirements
Module: rr_tag_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters (snoopers or cores), legal range 2..16.
REQ-002 SHALL have parameter TAG_SZ, default 2: tag width; TAG_SZ >= clog2(N_REQ) SHALL hold, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_rdy  in  N_REQ  bit i high = requester i is offering itself.
REQ-006 SHALL have port req_ack  out  N_REQ  one-hot; bit i high = requester i consumed this cycle.
REQ-007 SHALL have port tag  out  TAG_SZ  index of the offered requester, zero-extended.
REQ-008 SHALL have port rdy  out  1  tag valid.
REQ-009 SHALL have port ack  in  1  downstream accepts tag when rdy is high.

Function
REQ-010 SHALL implement two states: IDLE (rdy=0) and OFFER (rdy=1); tag and rdy SHALL be registered outputs.
REQ-011 SHALL hold a priority pointer ptr (0..N_REQ-1); selection SHALL scan indices ptr, ptr+1, ... and wrap from N_REQ-1 to 0, picking the first i with req_rdy[i]=1.
REQ-012 IDLE: if any req_rdy bit is set, SHALL latch the selected index into tag and enter OFFER on the next edge (1-cycle latency from req_rdy to rdy); otherwise SHALL stay in IDLE.
REQ-013 OFFER: tag SHALL remain stable until the ack cycle or until a withdrawal.
REQ-014 req_ack SHALL be combinational: req_ack[tag] = ack && state==OFFER && !rst; all other bits SHALL be 0.
REQ-015 On ack in OFFER, SHALL set ptr <= (tag+1) mod N_REQ.
REQ-016 On ack in OFFER, SHALL re-scan from (tag+1) mod N_REQ excluding index tag; if a hit is found, SHALL stay in OFFER with the new tag on the next edge, giving a grant every cycle under sustained load.
REQ-017 On ack in OFFER with no other requester, SHALL return to IDLE.
REQ-018 OFFER with req_rdy[tag]=0 and ack=0 (withdrawal): SHALL go to IDLE next edge with ptr unchanged.
REQ-019 Withdrawal and ack in the same cycle: ack SHALL take precedence, issuing req_ack and handling the cycle per REQ-015..017.
REQ-020 ack while in IDLE SHALL be ignored: no req_ack, no state change.
REQ-021 Arbitration SHALL be starvation-free: with all requesters continuously ready, grants SHALL cycle 0,1,...,N_REQ-1,0, and each requester SHALL wait at most N_REQ-1 grants.

Reset
REQ-022 On a clock edge with rst=1: state SHALL become IDLE, rdy 0, tag 0, ptr 0, and the optional counter 0.
REQ-023 Reset asserted while in OFFER SHALL suppress req_ack in that cycle (REQ-014), and the offered grant SHALL be discarded.
REQ-024 On the first edge after rst deasserts, SHALL arbitrate normally from ptr=0.

Configuration
REQ-025 Macro RR_TAG_ARBITER_GRANT_CNT_EN, when defined, SHALL add output port grant_cnt (out, 32 bits), incrementing by 1 on each cycle with rdy && ack, wrapping from 0xFFFFFFFF to 0, and cleared by rst.
REQ-026 Without RR_TAG_ARBITER_GRANT_CNT_EN, port grant_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 N_REQ=4, req_rdy=4'b1111 held, ack=1 continuously -> tag sequence 0,1,2,3,0 on consecutive cycles, rdy high every cycle after the first, req_ack one-hot matching tag.
REQ-028 req_rdy=4'b0100 from IDLE, ack=0 for 3 cycles then 1 -> rdy rises 1 cycle later, tag=2 stable for 4 cycles, req_ack=4'b0100 in the ack cycle, then IDLE with ptr=3.
REQ-029 ptr=3, req_rdy=4'b0011 -> tag=0 (wrap-around), then tag=1 after ack.
REQ-030 OFFER tag=1, req_rdy[1] dropped with ack=0 -> rdy=0 next cycle, ptr unchanged; req_rdy[1] dropped with ack=1 in the same cycle -> req_ack=4'b0010 issued.
REQ-031 rst=1 for one cycle while OFFER with ack=1 -> req_ack=0 that cycle, then rdy=0, tag=0, ptr=0; the next grant comes from index 0 if req_rdy[0]=1.
REQ-032 With RR_TAG_ARBITER_GRANT_CNT_EN defined, 10 acked grants -> grant_cnt=10; rst -> grant_cnt=0; a forced 0xFFFFFFFF plus 1 grant -> grant_cnt=0.
